// File: rtl/clock_ui_pkg.sv
// Shared types and defaults for the clock-setting UI controllers.
// No logic here: state encoding, default timing constants and a width helper.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EDIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int BLINK_HALF_DEF = 25_000_000;
    localparam int TIMEOUT_DEF    = 500_000_000;

    // Counter/index width for a range of n values; never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/field_select_fsm_if.sv
// Button-pulse inputs and field-select outputs of the clock-setting UI.
// Pure wiring: no latency, no backpressure (single-cycle pulses, never stalled).
interface field_select_fsm_if
    import clock_ui_pkg::*;
#(
    parameter int NUM_FIELDS = 6
) ();
    localparam int FW = width_of(NUM_FIELDS);

    logic                  edit_req;
    logic                  next_req;
    logic                  prev_req;
    logic [FW-1:0]         field;
    logic [NUM_FIELDS-1:0] field_sel;
    logic                  editing;
    logic                  blink;
    logic                  commit;
    logic                  abort;

    modport master (
        output edit_req, next_req, prev_req,
        input  field, field_sel, editing, blink, commit, abort
    );

    modport slave (
        input  edit_req, next_req, prev_req,
        output field, field_sel, editing, blink, commit, abort
    );

endinterface

// File: rtl/blink_gen.sv
// Square-wave blink enable, HALF cycles per phase, restartable to the visible phase.
// Latency 1 cycle from en/restart to blink; no backpressure.
module blink_gen
    import clock_ui_pkg::*;
#(
    parameter int HALF = BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic blink
);
    localparam int            CW       = width_of(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/field_select_fsm.sv
// Edit-mode controller: cursor over NUM_FIELDS fields, blink, commit/timeout abort.
// Latency 1 cycle request-to-output, all outputs registered; no backpressure.
module field_select_fsm
    import clock_ui_pkg::*;
#(
    parameter int NUM_FIELDS = 6,
    parameter int BLINK_HALF = BLINK_HALF_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               reset_n,
    field_select_fsm_if.slave bus
);
    localparam int            FW           = width_of(NUM_FIELDS);
    localparam int            TW           = width_of(TIMEOUT);
    localparam logic [FW-1:0] LAST_FIELD   = FW'(NUM_FIELDS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t                state;
    state_t                state_nxt;
    logic [FW-1:0]         field_q;
    logic [FW-1:0]         field_nxt;
    logic [NUM_FIELDS-1:0] field_sel_q;
    logic [NUM_FIELDS-1:0] field_sel_nxt;
    logic [TW-1:0]         tcnt;
    logic [TW-1:0]         tcnt_nxt;
    logic                  editing_q;
    logic                  commit_q;
    logic                  commit_nxt;
    logic                  abort_q;
    logic                  abort_nxt;
    logic                  activity;
    logic                  expired;
    logic                  blink_restart;
    logic                  blink_w;

    assign activity = (state == EDIT) && (bus.edit_req || bus.next_req || bus.prev_req);
    assign expired  = (state == EDIT) && (tcnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            field_q     <= '0;
            field_sel_q <= '0;
            tcnt        <= '0;
            editing_q   <= 1'b0;
            commit_q    <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            field_q     <= field_nxt;
            field_sel_q <= field_sel_nxt;
            tcnt        <= tcnt_nxt;
            editing_q   <= (state_nxt == EDIT);
            commit_q    <= commit_nxt;
            abort_q     <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        field_nxt     = field_q;
        commit_nxt    = 1'b0;
        abort_nxt     = 1'b0;
        blink_restart = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.edit_req) begin
                    state_nxt     = EDIT;
                    field_nxt     = '0;
                    blink_restart = 1'b1;
                end
            end
            EDIT: begin
                if (bus.edit_req) begin
                    state_nxt  = DONE;
                    commit_nxt = 1'b1;
                end else if (expired) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (bus.next_req ^ bus.prev_req) begin
                    // A move restarts the blink so the new field is shown at once.
                    blink_restart = 1'b1;
                    if (bus.next_req) begin
                        field_nxt = (field_q == LAST_FIELD) ? '0 : field_q + FW'(1);
                    end else begin
                        field_nxt = (field_q == '0) ? LAST_FIELD : field_q - FW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Counts idle cycles spent in EDIT; zero on entry, on activity and outside EDIT.
        tcnt_nxt = '0;
        if ((state == EDIT) && (state_nxt == EDIT) && !activity) begin
            tcnt_nxt = tcnt + TW'(1);
        end

        field_sel_nxt = '0;
        if (state_nxt == EDIT) begin
            field_sel_nxt = NUM_FIELDS'(1) << field_nxt;
        end
    end

    blink_gen #(
        .HALF(BLINK_HALF)
    ) u_blink_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_nxt == EDIT),
        .restart (blink_restart),
        .blink   (blink_w)
    );

    assign bus.field     = field_q;
    assign bus.field_sel = field_sel_q;
    assign bus.editing   = editing_q;
    assign bus.blink     = blink_w;
    assign bus.commit    = commit_q;
    assign bus.abort     = abort_q;

endmodule

// File: tb/tb_field_select_fsm.sv
// Directed bench for field_select_fsm with a cycle-level reference model and scoreboard.
module tb_field_select_fsm;

    localparam int NF   = 6;
    localparam int HALF = 4;
    localparam int TO   = 20;

    typedef struct packed {
        logic [2:0]    field;
        logic [NF-1:0] sel;
        logic          editing;
        logic          blink;
        logic          commit;
        logic          abort;
    } obs_t;

    logic clk;
    logic reset_n;

    field_select_fsm_if #(.NUM_FIELDS(NF)) bus ();

    field_select_fsm #(
        .NUM_FIELDS (NF),
        .BLINK_HALF (HALF),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model: 0 idle, 1 edit, 2 done
    int m_state  = 0;
    int m_field  = 0;
    int m_since  = 0;   // cycles since entry or last cursor move
    int m_idle   = 0;   // cycles since entry or last request in edit
    bit m_commit = 0;
    bit m_abort  = 0;

    function automatic obs_t model_out();
        obs_t o;
        o.field   = 3'(m_field);
        o.editing = (m_state == 1);
        o.sel     = o.editing ? NF'(1 << m_field) : '0;
        o.blink   = o.editing && (((m_since / HALF) % 2) == 0);
        o.commit  = m_commit;
        o.abort   = m_abort;
        return o;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_field  = 0;
        m_since  = 0;
        m_idle   = 0;
        m_commit = 0;
        m_abort  = 0;
    endtask

    task automatic model_step(input bit e, input bit n, input bit p);
        m_commit = 0;
        m_abort  = 0;
        if (m_state == 1) begin
            if (e) begin
                m_state  = 2;
                m_commit = 1;
            end else if (m_idle == TO - 1) begin
                m_state = 0;
                m_abort = 1;
            end else begin
                if (n && !p) begin
                    m_field = (m_field + 1) % NF;
                    m_since = 0;
                end else if (p && !n) begin
                    m_field = (m_field + NF - 1) % NF;
                    m_since = 0;
                end else begin
                    m_since++;
                end
                m_idle = (n || p) ? 0 : m_idle + 1;
            end
        end else if (m_state == 0) begin
            if (e) begin
                m_state = 1;
                m_field = 0;
                m_since = 0;
                m_idle  = 0;
            end
        end else begin
            m_state = 0;
        end
    endtask

    task automatic compare(input string tag);
        obs_t got;
        obs_t exp;
        got = '{field: bus.field, sel: bus.field_sel, editing: bus.editing,
                blink: bus.blink, commit: bus.commit, abort: bus.abort};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (field,sel,editing,blink,commit,abort)",
                   tag, got, exp);
        end
    endtask

    task automatic step(input bit e, input bit n, input bit p, input string tag);
        bus.edit_req = e;
        bus.next_req = n;
        bus.prev_req = p;
        model_step(e, n, p);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        bus.edit_req = 1'b0;
        bus.next_req = 1'b0;
        bus.prev_req = 1'b0;
        compare(tag);
    endtask

    task automatic wait_abort(input string tag);
        int found;
        found = -1;
        for (int i = 1; i <= 2 * TO && found < 0; i++) begin
            step(0, 0, 0, "idle_wait");
            if (bus.abort === 1'b1) found = i;
        end
        checks++;
        assert (found === TO) else begin
            errors++;
            $error("FAIL %s: abort after %0d cycles, expected %0d", tag, found, TO);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.edit_req = 1'b0;
        bus.next_req = 1'b0;
        bus.prev_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        compare("reset_state");
        reset_n = 1'b1;

        step(0, 0, 0, "idle_quiet");
        step(0, 1, 0, "idle_next_ignored");
        step(0, 0, 1, "idle_prev_ignored");
        step(1, 0, 0, "enter_edit");

        for (int i = 0; i < NF; i++) step(0, 1, 0, "next_step");
        step(0, 0, 1, "prev_wrap");
        repeat (3) step(0, 0, 1, "prev_step");
        repeat (5) step(0, 0, 0, "edit_idle_blink");
        step(0, 1, 1, "next_prev_together");
        repeat (3) step(0, 0, 0, "edit_idle_blink2");

        step(1, 1, 0, "commit_with_next");
        step(1, 0, 0, "done_ignores_edit");
        step(0, 0, 0, "back_idle");

        // Re-entry zeroes field; both-pulse must restart the timeout count
        step(1, 0, 0, "reenter");
        repeat (5) step(0, 0, 0, "idle_before_both");
        step(0, 1, 1, "both_clears_timeout");
        wait_abort("abort_after_activity");
        step(0, 0, 0, "abort_single_pulse");

        step(1, 0, 0, "enter_for_timeout");
        wait_abort("abort_after_entry");
        step(0, 0, 0, "post_abort_idle");

        step(1, 0, 0, "enter_for_reset");
        repeat (3) step(0, 1, 0, "next_to_3");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(model_out());
        compare("async_reset_immediate");
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        compare("reset_held");
        reset_n = 1'b1;
        step(0, 0, 0, "after_reset_idle");
        step(0, 1, 0, "after_reset_next_ignored");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
